// File: rtl/pixel_pkg.sv
// Shared constants, FSM states and the queued-pixel record for pixel_writer.
package pixel_pkg;
   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;
   localparam int ADDR_W       = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              color;
   } pix_entry_t;

   // Linear framebuffer address, computed at full ADDR_W width.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] y,
                                                  input logic [9:0] x,
                                                  input int unsigned w);
      return ADDR_W'(y) * ADDR_W'(w) + ADDR_W'(x);
   endfunction
endpackage

// File: rtl/pixel_fifo.sv
// Small first-word-fall-through FIFO holding pixels waiting for the framebuffer.
module pixel_fifo
   import pixel_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      full     = (count_q == (PTR_W+1)'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
   end

   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/pixel_writer.sv
// Queues drawn pixels into a framebuffer write port and performs full-screen
// clears after draining whatever was queued ahead of the clear request.
module pixel_writer
   import pixel_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int DEPTH    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [9:0]        in_x,
   input  logic [8:0]        in_y,
   input  logic              in_color,
   output logic              in_ready,
   input  logic              clear_req,
   input  logic              clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   input  logic              fb_wait,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_data,
   output logic [7:0]        drop_count
);
   localparam logic [10:0]       X_LIM     = 11'(SCREEN_W);
   localparam logic [9:0]        Y_LIM     = 10'(SCREEN_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

   state_t            state_q, state_d;
   logic              clear_pending_q, clear_pending_d;
   logic              color_q, color_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic              fb_data_q, fb_data_d;
   logic              clear_busy_q, clear_busy_d;
   logic              clear_done_q, clear_done_d;
   logic              last_wr_q, last_wr_d;
   logic [7:0]        drop_q, drop_d;

   logic       off_screen, accept, fifo_push, fifo_pop, fifo_full, fifo_empty;
   pix_entry_t push_entry, pop_entry;

   pixel_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(pix_entry_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (pop_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      off_screen       = ({1'b0, in_x} >= X_LIM) || ({1'b0, in_y} >= Y_LIM);
      in_ready         = !fifo_full && !clear_pending_q && (state_q != CLEAR);
      accept           = in_valid && in_ready;
      fifo_push        = accept && !off_screen;
      push_entry.addr  = pix_addr(in_y, in_x, SCREEN_W);
      push_entry.color = in_color;
      fifo_pop         = (state_q != CLEAR) && !fb_wait && !fifo_empty;

      state_d         = state_q;
      clear_pending_d = clear_pending_q;
      color_d         = color_q;
      sweep_d         = sweep_q;
      last_wr_d       = 1'b0;
      fb_we_d         = 1'b0;
      fb_addr_d       = fb_addr_q;
      fb_data_d       = fb_data_q;
      drop_d          = (accept && off_screen && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

      if (fifo_pop) begin
         fb_we_d   = 1'b1;
         fb_addr_d = pop_entry.addr;
         fb_data_d = pop_entry.color;
      end

      case (state_q)
         IDLE: begin
            // A pixel accepted alongside clear_req is already in the FIFO ahead of the sweep.
            if (clear_req) begin
               clear_pending_d = 1'b1;
               color_d         = clear_color;
               state_d         = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_d = CLEAR;
               sweep_d = '0;
            end
         end
         CLEAR: begin
            if (!fb_wait) begin
               fb_we_d   = 1'b1;
               fb_addr_d = sweep_q;
               fb_data_d = color_q;
               if (sweep_q == LAST_ADDR) begin
                  last_wr_d       = 1'b1;
                  state_d         = IDLE;
                  clear_pending_d = 1'b0;
                  sweep_d         = '0;
               end else begin
                  sweep_d = sweep_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      clear_busy_d = (state_d != IDLE);
      clear_done_d = last_wr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         clear_pending_q <= 1'b0;
         color_q         <= 1'b0;
         sweep_q         <= '0;
         fb_we_q         <= 1'b0;
         fb_addr_q       <= '0;
         fb_data_q       <= 1'b0;
         clear_busy_q    <= 1'b0;
         clear_done_q    <= 1'b0;
         last_wr_q       <= 1'b0;
         drop_q          <= '0;
      end else begin
         state_q         <= state_d;
         clear_pending_q <= clear_pending_d;
         color_q         <= color_d;
         sweep_q         <= sweep_d;
         fb_we_q         <= fb_we_d;
         fb_addr_q       <= fb_addr_d;
         fb_data_q       <= fb_data_d;
         clear_busy_q    <= clear_busy_d;
         clear_done_q    <= clear_done_d;
         last_wr_q       <= last_wr_d;
         drop_q          <= drop_d;
      end
   end

   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;
   assign drop_count = drop_q;
endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer on an 8x4 screen with a 4-deep FIFO.
module tb_pixel_writer;
   localparam int W    = 8;
   localparam int H    = 4;
   localparam int D    = 4;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [9:0]  in_x = '0;
   logic [8:0]  in_y = '0;
   logic        in_color = 1'b0;
   logic        clear_req = 1'b0;
   logic        clear_color = 1'b0;
   logic        fb_wait = 1'b0;
   logic        in_ready, clear_busy, clear_done, fb_we, fb_data;
   logic [18:0] fb_addr;
   logic [7:0]  drop_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pixel_writer #(.SCREEN_W(W), .SCREEN_H(H), .DEPTH(D)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_color    (in_color),
      .in_ready    (in_ready),
      .clear_req   (clear_req),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .fb_wait     (fb_wait),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data),
      .drop_count  (drop_count)
   );

   typedef struct {
      logic [9:0]  x;
      logic [8:0]  y;
      logic        c;
      logic        exp_we;
      logic [18:0] exp_addr;
      logic [7:0]  exp_drop;
   } vec_t;

   typedef struct {
      int addr;
      int data;
      bit is_pix;
      bit last;
   } wr_t;

   vec_t vecs[9];

   // Collected results of a clear sequence
   int wr_addr[$];
   int wr_data[$];
   int done_cnt, done_cyc, last_wr_cyc, ready_bad, wait_bad, waits_seen;

   // Reference model for the random phase
   wr_t expq[$];
   int  occ;
   int  mdrop;
   bit  clearing;
   bit  done_next;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      clear_req = 1'b0;
      clear_color = 1'b0;
      fb_wait = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Issues a clear (plus ignored re-requests) and records every write that follows.
   task automatic collect(input int total, input int wait_at, input logic clr, input int max_cyc);
      int wait_left;
      wait_left = 0;
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
      done_cyc = -10;
      last_wr_cyc = -10;
      ready_bad = 0;
      wait_bad = 0;
      waits_seen = 0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         fb_wait = (wait_left > 0);
         clear_req = (cyc == 0 || cyc == 1 || cyc == 20);
         clear_color = (cyc == 0) ? clr : ~clr;
         if (cyc != 0 && wr_addr.size() < total && in_ready !== 1'b0) ready_bad++;
         step();
         clear_req = 1'b0;
         if (fb_wait) begin
            wait_left--;
            waits_seen++;
            if (fb_we !== 1'b0) wait_bad++;
         end
         if (fb_we === 1'b1) begin
            wr_addr.push_back(int'(fb_addr));
            wr_data.push_back(int'(fb_data));
            last_wr_cyc = cyc;
            if (wait_at >= 0 && int'(fb_addr) == wait_at - 1) wait_left = 3;
         end
         if (clear_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      end
      fb_wait = 1'b0;
   endtask

   task automatic rnd_observe();
      wr_t  e;
      logic exp_done;
      exp_done = done_next;
      done_next = 1'b0;
      if (fb_wait) chk("rnd_wait_hold", 32'(fb_we), 0);
      if (fb_we === 1'b1) begin
         chk("rnd_write_expected", 32'(expq.size() != 0), 1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("rnd_addr", 32'(fb_addr), e.addr);
            chk("rnd_data", 32'(fb_data), e.data);
            if (e.is_pix) occ--;
            if (e.last) begin
               clearing = 1'b0;
               done_next = 1'b1;
            end
         end
      end
      chk("rnd_clear_done", 32'(clear_done), 32'(exp_done));
      chk("rnd_clear_busy", 32'(clear_busy), 32'(clearing));
      chk("rnd_drop", 32'(drop_count), mdrop);
   endtask

   initial begin
      int rx, ry, exp_a[$], exp_d[$], n;
      bit exp_ready, found;

      vecs[0] = '{10'd3,    9'd2,   1'b1, 1'b1, 19'd19, 8'd0};
      vecs[1] = '{10'd0,    9'd0,   1'b0, 1'b1, 19'd0,  8'd0};
      vecs[2] = '{10'd7,    9'd3,   1'b1, 1'b1, 19'd31, 8'd0};
      vecs[3] = '{10'd8,    9'd0,   1'b1, 1'b0, 19'd0,  8'd1};
      vecs[4] = '{10'd0,    9'd4,   1'b1, 1'b0, 19'd0,  8'd2};
      vecs[5] = '{10'd5,    9'd1,   1'b0, 1'b1, 19'd13, 8'd2};
      vecs[6] = '{10'd1023, 9'd511, 1'b1, 1'b0, 19'd0,  8'd3};
      vecs[7] = '{10'd7,    9'd0,   1'b1, 1'b1, 19'd7,  8'd3};
      vecs[8] = '{10'd0,    9'd3,   1'b1, 1'b1, 19'd24, 8'd3};

      // Reset state
      step();
      step();
      chk("rst_fb_we", 32'(fb_we), 0);
      chk("rst_fb_addr", 32'(fb_addr), 0);
      chk("rst_fb_data", 32'(fb_data), 0);
      chk("rst_clear_busy", 32'(clear_busy), 0);
      chk("rst_clear_done", 32'(clear_done), 0);
      chk("rst_drop", 32'(drop_count), 0);
      reset = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 1);

      // Single pixels into an empty FIFO
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_x = vecs[i].x;
         in_y = vecs[i].y;
         in_color = vecs[i].c;
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
         step();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_early_we", i), 32'(fb_we), 0);
         step();
         chk($sformatf("vec%0d_we", i), 32'(fb_we), 32'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_addr", i), 32'(fb_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_data", i), 32'(fb_data), 32'(vecs[i].c));
         end
         chk($sformatf("vec%0d_drop", i), 32'(drop_count), 32'(vecs[i].exp_drop));
         $display("[TB] vec %0d x=%0d y=%0d c=%0d we=%0d addr=%0d drop=%0d",
                  i, vecs[i].x, vecs[i].y, vecs[i].c, fb_we, fb_addr, drop_count);
      end

      // Drop counter saturation
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_x = 10'd9;
         in_y = 9'd0;
         step();
         if (i == 250) chk("drop_254", 32'(drop_count), 254);
      end
      in_valid = 1'b0;
      chk("drop_sat", 32'(drop_count), 255);
      $display("[TB] drop saturation drop=%0d", drop_count);

      // Back-to-back pushes under fb_wait, then release
      do_reset();
      fb_wait = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_x = 10'(i + 1);
         in_y = 9'(i % 4);
         in_color = 1'(i % 2 == 0);
         chk($sformatf("stall_ready%0d", i), 32'(in_ready), 32'(i < 4));
         step();
         chk($sformatf("stall_we%0d", i), 32'(fb_we), 0);
      end
      in_valid = 1'b0;
      fb_wait = 1'b0;
      exp_a = '{1, 10, 19, 28};
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("release_we%0d", k), 32'(fb_we), 32'(k < 4));
         if (k < 4) begin
            chk($sformatf("release_addr%0d", k), 32'(fb_addr), exp_a[k]);
            chk($sformatf("release_data%0d", k), 32'(fb_data), 32'(k % 2 == 0));
         end
      end
      $display("[TB] stall/release sequence done");

      // Two queued pixels ahead of a clear
      do_reset();
      fb_wait = 1'b1;
      in_valid = 1'b1; in_x = 10'd2; in_y = 9'd1; in_color = 1'b1;
      step();
      in_x = 10'd6; in_y = 9'd3;
      step();
      in_valid = 1'b0;
      collect(NPIX + 2, -1, 1'b0, 150);
      exp_a = '{10, 30};
      exp_d = '{1, 1};
      for (int a = 0; a < NPIX; a++) begin
         exp_a.push_back(a);
         exp_d.push_back(0);
      end
      chk("clr_write_count", wr_addr.size(), NPIX + 2);
      n = (wr_addr.size() < exp_a.size()) ? wr_addr.size() : exp_a.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("clr_addr%0d", i), wr_addr[i], exp_a[i]);
         chk($sformatf("clr_data%0d", i), wr_data[i], exp_d[i]);
      end
      chk("clr_done_count", done_cnt, 1);
      chk("clr_done_timing", done_cyc, last_wr_cyc + 1);
      chk("clr_ready_low", ready_bad, 0);
      chk("clr_busy_end", 32'(clear_busy), 0);
      chk("clr_ready_end", 32'(in_ready), 1);
      $display("[TB] clear after 2 pixels: %0d writes, done=%0d", wr_addr.size(), done_cnt);

      // Stall mid-sweep at address 10
      do_reset();
      collect(NPIX, 10, 1'b1, 150);
      chk("stall_sweep_count", wr_addr.size(), NPIX);
      n = (wr_addr.size() < NPIX) ? wr_addr.size() : NPIX;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("stall_sweep_addr%0d", i), wr_addr[i], i);
         chk($sformatf("stall_sweep_data%0d", i), wr_data[i], 1);
      end
      chk("stall_sweep_waits", waits_seen, 3);
      chk("stall_sweep_we_held", wait_bad, 0);
      chk("stall_sweep_done", done_cnt, 1);
      $display("[TB] stalled sweep: %0d writes, waits=%0d", wr_addr.size(), waits_seen);

      // Reset in the middle of a sweep
      do_reset();
      clear_req = 1'b1;
      clear_color = 1'b1;
      step();
      clear_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (fb_we === 1'b1 && fb_addr == 19'd14) begin
            found = 1'b1;
            break;
         end
      end
      chk("abort_reached", 32'(found), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_we", 32'(fb_we), 0);
      chk("abort_addr", 32'(fb_addr), 0);
      chk("abort_data", 32'(fb_data), 0);
      chk("abort_busy", 32'(clear_busy), 0);
      chk("abort_done", 32'(clear_done), 0);
      chk("abort_ready", 32'(in_ready), 1);
      n = 0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (fb_we === 1'b1) n++;
         if (clear_done === 1'b1) done_cnt++;
      end
      chk("abort_no_writes", n, 0);
      chk("abort_no_done", done_cnt, 0);
      $display("[TB] reset mid-sweep sequence done");

      // Randomized traffic against the reference model
      do_reset();
      expq.delete();
      occ = 0;
      mdrop = 0;
      clearing = 1'b0;
      done_next = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         rx = int'($urandom_range(0, 9));
         ry = int'($urandom_range(0, 5));
         in_valid = ($urandom_range(0, 3) != 0);
         in_x = 10'(rx);
         in_y = 9'(ry);
         in_color = 1'($urandom_range(0, 1));
         fb_wait = ($urandom_range(0, 4) == 0);
         clear_req = ($urandom_range(0, 59) == 0);
         clear_color = 1'($urandom_range(0, 1));
         exp_ready = (occ < D) && !clearing;
         chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
         if (in_valid && exp_ready) begin
            if (rx >= W || ry >= H) begin
               if (mdrop < 255) mdrop++;
            end else begin
               expq.push_back('{addr: ry * W + rx, data: int'(in_color), is_pix: 1'b1, last: 1'b0});
               occ++;
            end
         end
         if (clear_req && !clearing) begin
            clearing = 1'b1;
            for (int a = 0; a < NPIX; a++)
               expq.push_back('{addr: a, data: int'(clear_color), is_pix: 1'b0, last: (a == NPIX - 1)});
         end
         step();
         rnd_observe();
      end
      in_valid = 1'b0;
      clear_req = 1'b0;
      fb_wait = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (expq.size() == 0 && !done_next) break;
         step();
         rnd_observe();
      end
      chk("rnd_drained", expq.size(), 0);
      $display("[TB] random phase done, drops=%0d", mdrop);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
